// File: rtl/id_ex_stage_if.sv
// Handshake and operand bundle between decode, the ID/EX register and the ALU.
// slave: seen by id_ex_stage; master: seen by the driver/consumer around it.
interface id_ex_stage_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic [3:0]  in_alu_op;
    logic        in_src1_pc;
    logic        in_src2_imm;
    logic [4:0]  in_rd_addr;
    logic        in_rd_we;
    logic        fwd_we;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] out_pc;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we;

    modport slave (
        input  flush, in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data,
               in_rs2_data, in_imm, in_alu_op, in_src1_pc, in_src2_imm,
               in_rd_addr, in_rd_we, fwd_we, fwd_rd, fwd_data, out_ready,
        output in_ready, out_valid, alu_op, alu_in1, alu_in2, out_pc,
               out_rd_addr, out_rd_we
    );

    modport master (
        output flush, in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data,
               in_rs2_data, in_imm, in_alu_op, in_src1_pc, in_src2_imm,
               in_rd_addr, in_rd_we, fwd_we, fwd_rd, fwd_data, out_ready,
        input  in_ready, out_valid, alu_op, alu_in1, alu_in2, out_pc,
               out_rd_addr, out_rd_we
    );
endinterface

// File: rtl/id_ex_stage.sv
// Single-entry ID/EX pipeline register feeding the ALU operand muxes.
// Define ID_EX_FORWARD_EN to forward the writeback result into rs1/rs2 values.
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_SLL  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_LT   4'd8
`define ALU_LTU  4'd9
`endif

module id_ex_stage (
    input  logic           clk,
    input  logic           rst,
    id_ex_stage_if.slave   bus
);
    logic        valid_q,    valid_d;
    logic [31:0] pc_q,       pc_d;
    logic [4:0]  rs1_addr_q, rs1_addr_d;
    logic [4:0]  rs2_addr_q, rs2_addr_d;
    logic [31:0] rs1_val_q,  rs1_val_d;
    logic [31:0] rs2_val_q,  rs2_val_d;
    logic [31:0] imm_q,      imm_d;
    logic [3:0]  op_q,       op_d;
    logic        src1_pc_q,  src1_pc_d;
    logic        src2_imm_q, src2_imm_d;
    logic [4:0]  rd_addr_q,  rd_addr_d;
    logic        rd_we_q,    rd_we_d;

    logic        load;
    logic        drain;
    logic [31:0] operand2;
    logic        is_shift;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready && !bus.flush;
    assign drain        = valid_q && bus.out_ready;

`ifdef ID_EX_FORWARD_EN
    // x0 never matches: writes to it are architecturally discarded.
    function automatic logic [31:0] fwd_pick(input logic [4:0] addr, input logic [31:0] dflt,
                                             input logic we, input logic [4:0] rd,
                                             input logic [31:0] data);
        return (we && rd != 5'd0 && rd == addr) ? data : dflt;
    endfunction
`endif

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rs1_val_d  = rs1_val_q;
        rs2_val_d  = rs2_val_q;
        imm_d      = imm_q;
        op_d       = op_q;
        src1_pc_d  = src1_pc_q;
        src2_imm_d = src2_imm_q;
        rd_addr_d  = rd_addr_q;
        rd_we_d    = rd_we_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d    = 1'b1;
            pc_d       = bus.in_pc;
            rs1_addr_d = bus.in_rs1_addr;
            rs2_addr_d = bus.in_rs2_addr;
            imm_d      = bus.in_imm;
            op_d       = bus.in_alu_op;
            src1_pc_d  = bus.in_src1_pc;
            src2_imm_d = bus.in_src2_imm;
            rd_addr_d  = bus.in_rd_addr;
            rd_we_d    = bus.in_rd_we;
`ifdef ID_EX_FORWARD_EN
            rs1_val_d  = fwd_pick(bus.in_rs1_addr, bus.in_rs1_data, bus.fwd_we, bus.fwd_rd, bus.fwd_data);
            rs2_val_d  = fwd_pick(bus.in_rs2_addr, bus.in_rs2_data, bus.fwd_we, bus.fwd_rd, bus.fwd_data);
`else
            rs1_val_d  = bus.in_rs1_data;
            rs2_val_d  = bus.in_rs2_data;
`endif
        end else if (drain) begin
            valid_d = 1'b0;
        end
`ifdef ID_EX_FORWARD_EN
        // A held entry keeps tracking writeback so it never issues a stale value.
        if (valid_q && !load) begin
            rs1_val_d = fwd_pick(rs1_addr_q, rs1_val_q, bus.fwd_we, bus.fwd_rd, bus.fwd_data);
            rs2_val_d = fwd_pick(rs2_addr_q, rs2_val_q, bus.fwd_we, bus.fwd_rd, bus.fwd_data);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= 32'd0;
            rs1_addr_q <= 5'd0;
            rs2_addr_q <= 5'd0;
            rs1_val_q  <= 32'd0;
            rs2_val_q  <= 32'd0;
            imm_q      <= 32'd0;
            op_q       <= 4'd0;
            src1_pc_q  <= 1'b0;
            src2_imm_q <= 1'b0;
            rd_addr_q  <= 5'd0;
            rd_we_q    <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rs1_val_q  <= rs1_val_d;
            rs2_val_q  <= rs2_val_d;
            imm_q      <= imm_d;
            op_q       <= op_d;
            src1_pc_q  <= src1_pc_d;
            src2_imm_q <= src2_imm_d;
            rd_addr_q  <= rd_addr_d;
            rd_we_q    <= rd_we_d;
        end
    end

    assign operand2 = src2_imm_q ? imm_q : rs2_val_q;
    assign is_shift = (op_q == `ALU_SLL) || (op_q == `ALU_SRL) || (op_q == `ALU_SRA);

    assign bus.out_valid   = valid_q;
    assign bus.alu_op      = op_q;
    assign bus.alu_in1     = src1_pc_q ? pc_q : rs1_val_q;
    assign bus.alu_in2     = is_shift ? {27'd0, operand2[4:0]} : operand2;
    assign bus.out_pc      = pc_q;
    assign bus.out_rd_addr = rd_addr_q;
    assign bus.out_rd_we   = rd_we_q && valid_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: operand selection, shift masking, stall,
// flush, asynchronous reset and (when ID_EX_FORWARD_EN is defined) forwarding.
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_SLL  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_LT   4'd8
`define ALU_LTU  4'd9
`endif

module tb_id_ex_stage;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] rs1a, input logic [31:0] rs1d,
                         input logic [4:0] rs2a, input logic [31:0] rs2d, input logic [31:0] imm,
                         input logic [3:0] op, input logic s1pc, input logic s2imm,
                         input logic [4:0] rd, input logic we);
        bus.in_valid    = 1'b1;
        bus.in_pc       = pc;
        bus.in_rs1_addr = rs1a;
        bus.in_rs1_data = rs1d;
        bus.in_rs2_addr = rs2a;
        bus.in_rs2_data = rs2d;
        bus.in_imm      = imm;
        bus.in_alu_op   = op;
        bus.in_src1_pc  = s1pc;
        bus.in_src2_imm = s2imm;
        bus.in_rd_addr  = rd;
        bus.in_rd_we    = we;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_pc = '0;
        bus.in_rs1_addr = '0; bus.in_rs2_addr = '0; bus.in_rs1_data = '0; bus.in_rs2_data = '0;
        bus.in_imm = '0; bus.in_alu_op = '0; bus.in_src1_pc = 1'b0; bus.in_src2_imm = 1'b0;
        bus.in_rd_addr = '0; bus.in_rd_we = 1'b0;
        bus.fwd_we = 1'b0; bus.fwd_rd = '0; bus.fwd_data = '0;
        bus.out_ready = 1'b1;

        #12;
        check("rst_valid",   {31'd0, bus.out_valid}, 32'd0);
        check("rst_ready",   {31'd0, bus.in_ready}, 32'd1);
        check("rst_rd_we",   {31'd0, bus.out_rd_we}, 32'd0);
        check("rst_op",      {28'd0, bus.alu_op}, 32'd0);
        check("rst_in1",     bus.alu_in1, 32'd0);
        check("rst_in2",     bus.alu_in2, 32'd0);
        check("rst_pc",      bus.out_pc, 32'd0);
        check("rst_rd",      {27'd0, bus.out_rd_addr}, 32'd0);
        rst = 1'b0;
        step();
        check("idle_valid",  {31'd0, bus.out_valid}, 32'd0);
        check("idle_ready",  {31'd0, bus.in_ready}, 32'd1);

        // ADD rs1 + imm
        offer(32'h100, 5'd1, 32'h10, 5'd2, 32'h55, 32'hFFFF_FFF0, `ALU_ADD, 1'b0, 1'b1, 5'd3, 1'b1);
        step();
        check("add_valid",   {31'd0, bus.out_valid}, 32'd1);
        check("add_op",      {28'd0, bus.alu_op}, {28'd0, `ALU_ADD});
        check("add_in1",     bus.alu_in1, 32'h10);
        check("add_in2",     bus.alu_in2, 32'hFFFF_FFF0);
        check("add_pc",      bus.out_pc, 32'h100);
        check("add_rd",      {27'd0, bus.out_rd_addr}, 32'd3);
        check("add_rd_we",   {31'd0, bus.out_rd_we}, 32'd1);

        // SRA from rs2: shift amount masked to 5 bits
        offer(32'h104, 5'd4, 32'h8000_0000, 5'd6, 32'h0000_0123, 32'h0, `ALU_SRA, 1'b0, 1'b0, 5'd7, 1'b1);
        step();
        check("sra_op",      {28'd0, bus.alu_op}, {28'd0, `ALU_SRA});
        check("sra_in1",     bus.alu_in1, 32'h8000_0000);
        check("sra_in2",     bus.alu_in2, 32'h0000_0003);

        // SRL from immediate, upper bits of imm masked
        offer(32'h108, 5'd4, 32'h0, 5'd6, 32'h0, 32'hFFFF_FFE5, `ALU_SRL, 1'b0, 1'b1, 5'd8, 1'b1);
        step();
        check("srl_in2",     bus.alu_in2, 32'h0000_0005);

        // AUIPC-style: pc + imm
        offer(32'h8000_0004, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0000_1000, `ALU_ADD, 1'b1, 1'b1, 5'd9, 1'b1);
        step();
        check("auipc_in1",   bus.alu_in1, 32'h8000_0004);
        check("auipc_in2",   bus.alu_in2, 32'h0000_1000);

        // Stall three cycles with the next instruction offered
        bus.out_ready = 1'b0;
        offer(32'h200, 5'd1, 32'h7, 5'd2, 32'h3, 32'h0, `ALU_SUB, 1'b0, 1'b0, 5'd10, 1'b1);
        #1;
        check("stall_ready0", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ready", {31'd0, bus.in_ready}, 32'd0);
            check("stall_pc",    bus.out_pc, 32'h8000_0004);
            check("stall_in1",   bus.alu_in1, 32'h8000_0004);
            check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("unstall_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        check("unstall_pc",  bus.out_pc, 32'h200);
        check("unstall_op",  {28'd0, bus.alu_op}, {28'd0, `ALU_SUB});
        check("unstall_in2", bus.alu_in2, 32'h3);
        offer(32'h204, 5'd1, 32'h9, 5'd2, 32'h4, 32'h0, `ALU_XOR, 1'b0, 1'b0, 5'd11, 1'b1);
        step();
        check("b2b_pc",      bus.out_pc, 32'h204);
        check("b2b_valid",   {31'd0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, bus.out_valid}, 32'd0);
        check("drain_rd_we", {31'd0, bus.out_rd_we}, 32'd0);

        // Forwarding on load, while held, and x0 ignored
        bus.out_ready = 1'b0;
        offer(32'h240, 5'd5, 32'h1, 5'd6, 32'h2, 32'h0, `ALU_ADD, 1'b0, 1'b0, 5'd12, 1'b1);
        bus.fwd_we = 1'b1; bus.fwd_rd = 5'd5; bus.fwd_data = 32'hAA;
        step();
        bus.in_valid = 1'b0;
        check("fwd_load_in1", bus.alu_in1, FWD ? 32'hAA : 32'h1);
        check("fwd_load_in2", bus.alu_in2, 32'h2);
        bus.fwd_data = 32'hBB;
        step();
        check("fwd_held_in1", bus.alu_in1, FWD ? 32'hBB : 32'h1);
        bus.fwd_rd = 5'd0; bus.fwd_data = 32'hCC;
        step();
        check("fwd_x0_in1",  bus.alu_in1, FWD ? 32'hBB : 32'h1);
        bus.fwd_we = 1'b0;

        // Flush with entry held and new instruction offered
        offer(32'h300, 5'd1, 32'h77, 5'd2, 32'h88, 32'h0, `ALU_OR, 1'b0, 1'b0, 5'd13, 1'b1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush_rd_we", {31'd0, bus.out_rd_we}, 32'd0);
        check("flush_pc",    bus.out_pc, 32'h240);
        step();
        check("flush_after", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset in the middle of a stall
        bus.out_ready = 1'b0;
        offer(32'h400, 5'd1, 32'h55, 5'd2, 32'h66, 32'h0, `ALU_AND, 1'b0, 1'b0, 5'd14, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("pre_arst_valid", {31'd0, bus.out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid",  {31'd0, bus.out_valid}, 32'd0);
        check("arst_ready",  {31'd0, bus.in_ready}, 32'd1);
        check("arst_in1",    bus.alu_in1, 32'd0);
        check("arst_pc",     bus.out_pc, 32'd0);
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register that sits directly upstream of the ALU. It accepts one decoded instruction per handshake and selects ALU operands: register value or PC for operand 1, register value or immediate for operand 2. It masks shift amounts and optionally forwards a writeback result into operands. It drives the ALU's `op`/`in1`/`in2` plus the destination metadata that the following stage consumes.

## Interface
Parameters: none. Opcode values come from `alu_defs.v` (`ALU_ADD` … `ALU_LTU`, 4 bits).

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  discard the held instruction and any instruction offered this cycle
- in_valid  in  1  upstream offers an instruction
- in_ready  out  1  stage can accept; `!out_valid || out_ready`, combinational
- in_pc  in  32  instruction address
- in_rs1_addr, in_rs2_addr  in  5  source register indices
- in_rs1_data, in_rs2_data  in  32  register-file read values
- in_imm  in  32  sign-extended immediate
- in_alu_op  in  4  ALU opcode
- in_src1_pc  in  1  operand 1 = PC instead of rs1
- in_src2_imm  in  1  operand 2 = immediate instead of rs2
- in_rd_addr  in  5  destination register
- in_rd_we  in  1  destination write enable
- fwd_we  in  1  writeback is writing this cycle
- fwd_rd  in  5  writeback destination
- fwd_data  in  32  writeback value
- out_valid  out  1  held instruction valid
- out_ready  in  1  downstream accepts held instruction
- alu_op  out  4  to ALU `op`
- alu_in1, alu_in2  out  32  to ALU `in1`/`in2`
- out_pc  out  32  held PC
- out_rd_addr  out  5  held destination
- out_rd_we  out  1  held write enable; forced 0 when `out_valid` is 0

## Operation
- The stage has a single entry. Its registers are valid, pc, rs1_addr, rs2_addr, rs1_val, rs2_val, imm, op, src1_pc, src2_imm, rd_addr and rd_we.
- Load occurs when `in_valid && in_ready && !flush`. Every field is captured and valid is set to 1.
- Drain occurs when `out_valid && out_ready`. If no load happens in the same cycle, valid is cleared to 0.
- Load and drain in the same cycle give full throughput. The new entry replaces the old one.
- `flush` has top priority. Next cycle valid is 0, and the offered instruction is dropped even if `in_ready` is high.
- Outputs are combinational muxes of registered state only. There is no path from `in_*` to `alu_*`.
  - `alu_in1 = src1_pc ? pc : rs1_val`
  - operand 2 is `src2_imm ? imm : rs2_val`
  - When op is `ALU_SLL`, `ALU_SRL` or `ALU_SRA`, `alu_in2 = {27'b0, operand2[4:0]}`. Otherwise `alu_in2` = operand 2.
- Register x0 is never treated as a forwarding match, so `fwd_rd == 0` is ignored.

## Timing
- Reset clears all registers to 0. Outputs during reset:
  - `out_valid = 0`, `out_rd_we = 0`, `alu_op = 4'd0`, `alu_in1 = 0`, `alu_in2 = 0`, `out_pc = 0`, `out_rd_addr = 0`
  - `in_ready = 1`
- Latency: an instruction accepted at edge N appears on the outputs after edge N. It is visible to the ALU in cycle N+1.
- Throughput is 1 per cycle when `out_ready` is held high.
- Stall: `out_valid && !out_ready` gives `in_ready = 0`. The held entry stays stable except for forwarding updates.
- Reset asserted mid-stall: valid drops immediately (asynchronous). The held instruction is lost.
- Flush together with out_ready: the instruction counts as not consumed downstream. Downstream must also honour `flush`.

## Configuration
- `ID_EX_FORWARD_EN` defined: forwarding is active.
  - On load, `rs1_val = (fwd_we && fwd_rd != 0 && fwd_rd == in_rs1_addr) ? fwd_data : in_rs1_data`; rs2 uses the same rule.
  - While valid and no load, a matching write updates the held rs1_val/rs2_val on that edge. This happens regardless of the src1_pc/src2_imm selects.
- `ID_EX_FORWARD_EN` undefined:
  - `fwd_*` ports exist but are ignored.
  - Operands are always taken from `in_rs*_data`, and held values never change.

## Test plan
- Reset then idle:
  - `out_valid = 0`, `in_ready = 1`, `alu_in1 = alu_in2 = 0`.
- Load ADD with rs1 = 0x10, imm = 0xFFFFFFF0, src2_imm = 1, out_ready = 1:
  - next cycle `alu_op = ALU_ADD`, `alu_in1 = 0x10`, `alu_in2 = 0xFFFFFFF0`, `out_valid = 1`.
- Load SRA with rs2 = 0x00000123:
  - `alu_in2 = 0x00000003`.
- Load AUIPC-style op with src1_pc = 1 and pc = 0x80000004:
  - `alu_in1 = 0x80000004`.
- Stall with out_ready = 0 for 3 cycles, back-to-back in_valid:
  - `in_ready = 0`, outputs stable.
  - After out_ready = 1, the next instruction loads in the same cycle and there are no bubbles.
- With `ID_EX_FORWARD_EN`:
  - Load rs1_addr = 5 with in_rs1_data = 0x1 while fwd x5 = 0xAA → `alu_in1 = 0xAA`.
  - While stalled, fwd x5 = 0xBB → `alu_in1 = 0xBB` next cycle.
  - fwd x0 = 0xCC → no change.
  - Without the macro, `alu_in1 = 0x1` throughout.
- Flush with an entry held and in_valid = 1:
  - next cycle `out_valid = 0`, `out_rd_we = 0`, and the offered instruction does not appear.
